system_ir_tx: RTL and testbench

Avalon-MM slave that transmits one 32-bit NEC-format infrared frame per software request on a modulated open-carrier LED output. It is the transmit counterpart of the IR input PIO on the system bus. Software loads the frame word and sets start. The block generates leader, 32 pulse-distance-coded bits (LSB first) and a stop mark on the carrier, then raises a maskable done interrupt.

---
 rtl/system_ir_tx_pkg.sv | 30 +++
 rtl/system_ir_carrier_gen.sv | 28 ++
 rtl/system_ir_tx.sv | 126 ++++++++++++
 tb/tb_system_ir_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/system_ir_tx_pkg.sv
// Shared types and constants for the NEC infrared transmitter: FSM states,
// per-state durations in NEC units, and register addresses.
package system_ir_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5
  } state_t;

  localparam logic [4:0] LEAD_MARK_UNITS  = 5'd16;
  localparam logic [4:0] LEAD_SPACE_UNITS = 5'd8;
  localparam logic [4:0] BIT_MARK_UNITS   = 5'd1;
  localparam logic [4:0] ZERO_SPACE_UNITS = 5'd1;
  localparam logic [4:0] ONE_SPACE_UNITS  = 5'd3;
  localparam logic [4:0] STOP_MARK_UNITS  = 5'd1;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_DONE = 2'd3;

  function automatic logic is_mark(input state_t s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/system_ir_carrier_gen.sv
// Free-running carrier divider: high for the first half of each period,
// with a synchronous phase restart so every mark begins on a high half.
module system_ir_carrier_gen #(
  parameter int CARRIER_DIV = 1316
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic carrier
);

  localparam int PW = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;

  logic [PW-1:0] phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (restart || (phase == PW'(CARRIER_DIV - 1))) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign carrier = (phase < PW'(CARRIER_DIV / 2));

endmodule

// File: rtl/system_ir_tx.sv
// Avalon-MM NEC infrared transmitter: register file, frame FSM, per-state
// duration counter and LSB-first shift register driving a modulated LED.
module system_ir_tx
  import system_ir_tx_pkg::*;
#(
  parameter int UNIT_CYCLES = 28125,
  parameter int CARRIER_DIV = 1316
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        out_port
);

  localparam int CW = $clog2(16 * UNIT_CYCLES + 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, dur_limit;
  logic [4:0]    units, bit_idx;
  logic [31:0]   data_reg, shift_reg, rd_mux;
  logic          cnt_last, busy, mark, mask, done, carrier, restart;
  logic          wr, start_req, abort_req, done_set;

  // Bus handshake: a write is chipselect with write_n low; no wait states.
  assign wr        = chipselect && !write_n;
  assign start_req = wr && (address == ADDR_CTRL) && writedata[0] && !writedata[1];
  assign abort_req = wr && (address == ADDR_CTRL) && writedata[1];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (start_req) state_next = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (cnt_last)  state_next = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (cnt_last)  state_next = ST_BIT_MARK;
      ST_BIT_MARK:   if (cnt_last)  state_next = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (cnt_last)  state_next = (bit_idx == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
      ST_STOP_MARK:  if (cnt_last)  state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
    if (abort_req) state_next = ST_IDLE;
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    mark  = is_mark(state);
    units = 5'd0;
    case (state)
      ST_LEAD_MARK:  units = LEAD_MARK_UNITS;
      ST_LEAD_SPACE: units = LEAD_SPACE_UNITS;
      ST_BIT_MARK:   units = BIT_MARK_UNITS;
      ST_BIT_SPACE:  units = shift_reg[0] ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
      ST_STOP_MARK:  units = STOP_MARK_UNITS;
      default:       units = 5'd0;
    endcase
    dur_limit = CW'(units) * CW'(UNIT_CYCLES);
    cnt_last  = (cnt == dur_limit - CW'(1));
    done_set  = (state == ST_STOP_MARK) && cnt_last && !abort_req;
    restart   = is_mark(state_next) && (state_next != state);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      cnt <= (state_next != state) ? '0 : cnt + CW'(1);
      if ((state == ST_IDLE) && (state_next == ST_LEAD_MARK)) begin
        shift_reg <= data_reg;
        bit_idx   <= '0;
      end else if ((state == ST_BIT_SPACE) && cnt_last) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 5'd1;
      end
    end
  end

  system_ir_carrier_gen #(.CARRIER_DIV(CARRIER_DIV)) u_carrier (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .carrier (carrier)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = data_reg;
      ADDR_CTRL: rd_mux = {31'b0, busy};
      ADDR_MASK: rd_mux = {31'b0, mask};
      ADDR_DONE: rd_mux = {31'b0, done};
      default:   rd_mux = '0;
    endcase
  end

  // A completion in the same cycle as a W1C keeps done set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg <= '0;
      mask     <= 1'b0;
      done     <= 1'b0;
      readdata <= '0;
      out_port <= 1'b0;
    end else begin
      if (wr && (address == ADDR_DATA) && !busy) data_reg <= writedata;
      if (wr && (address == ADDR_MASK))          mask     <= writedata[0];
      if (done_set)                                             done <= 1'b1;
      else if (wr && (address == ADDR_DONE) && writedata[0])    done <= 1'b0;
      readdata <= rd_mux;
      out_port <= mark && carrier;
    end
  end

  assign irq = done && mask;

endmodule

// File: tb/tb_system_ir_tx.sv
// Directed bench for system_ir_tx with short units: frame waveforms against
// a cycle model built from the frame word, plus register and boundary cases.
module tb_system_ir_tx;

  localparam int UC = 4;
  localparam int CD = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        out_port;

  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];

  system_ir_tx #(.UNIT_CYCLES(UC), .CARRIER_DIV(CD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic push_mark(input int u);
    for (int i = 0; i < u * UC; i++) exp_q.push_back(1'((i % CD) < (CD / 2)));
  endtask

  task automatic push_space(input int u);
    for (int i = 0; i < u * UC; i++) exp_q.push_back(1'b0);
  endtask

  // Called right after the start write's edge; follows out_port until busy drops.
  task automatic run_frame(input string tag, input logic [31:0] f, input int exp_cycles);
    int cycles;
    int mism;
    logic [0:0] e;
    cycles = 0;
    mism = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    push_mark(16);
    push_space(8);
    for (int b = 0; b < 32; b++) begin
      push_mark(1);
      push_space(f[b] ? 3 : 1);
    end
    push_mark(1);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!dut.busy) break;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      if (out_port !== e) mism++;
      cycles++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    if (out_port !== e) mism++;
    check({tag, "_len"}, cycles, exp_cycles);
    check({tag, "_wave"}, mism, 0);
  endtask

  logic [31:0] d;
  int ones;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_out", {31'b0, out_port}, 32'h0);
    bus_read(2'd1, d); check("rst_busy", d, 32'h0);
    bus_read(2'd0, d); check("rst_data", d, 32'h0);

    // All-zero frame, mask off: capture set but no irq
    bus_write(2'd0, 32'h0);
    bus_write(2'd2, 32'h0);
    bus_write(2'd1, 32'h1);
    run_frame("zero", 32'h0, 356);
    check("zero_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd3, d); check("zero_done", d, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d); check("zero_done_clr", d, 32'h0);

    // All-ones frame with irq enabled
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h1);
    bus_write(2'd1, 32'h1);
    run_frame("ones", 32'hFFFF_FFFF, 612);
    check("ones_irq", {31'b0, irq}, 32'h1);
    bus_read(2'd3, d); check("ones_done", d, 32'h1);
    bus_write(2'd3, 32'h1);
    @(negedge clk);
    check("w1c_irq", {31'b0, irq}, 32'h0);

    // Mixed frame: bit order is LSB first
    bus_write(2'd0, 32'h00FF_00FF);
    bus_write(2'd1, 32'h1);
    run_frame("mixed", 32'h00FF_00FF, 484);
    bus_write(2'd3, 32'h1);

    // New data and start while busy are both ignored
    bus_write(2'd0, 32'h1234_5678);
    bus_write(2'd1, 32'h1);
    fork
      run_frame("mid", 32'h1234_5678, 460);
      begin
        repeat (30) @(negedge clk);
        bus_write(2'd0, 32'hAAAA_AAAA);
        bus_write(2'd1, 32'h1);
        bus_read(2'd1, d); check("mid_busy", d, 32'h1);
      end
    join
    bus_read(2'd0, d); check("mid_data_kept", d, 32'h1234_5678);
    bus_write(2'd3, 32'h1);

    // Start and abort together: stays idle
    bus_write(2'd1, 32'h3);
    bus_read(2'd1, d); check("start_abort_busy", d, 32'h0);
    check("start_abort_out", {31'b0, out_port}, 32'h0);

    // Abort at cycle 50 (inside the leader mark)
    bus_write(2'd0, 32'h0000_ABCD);
    bus_write(2'd1, 32'h1);
    repeat (48) @(negedge clk);
    bus_write(2'd1, 32'h2);
    @(negedge clk);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_port !== 1'b0) ones++;
    end
    check("abort_out_zero", ones, 0);
    bus_read(2'd1, d); check("abort_busy", d, 32'h0);
    bus_read(2'd3, d); check("abort_done", d, 32'h0);
    bus_read(2'd0, d); check("abort_data", d, 32'h0000_ABCD);

    // Completion and W1C on the same edge: set wins
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'h1);
    fork
      run_frame("setw1c", 32'h0, 356);
      begin
        repeat (355) @(negedge clk);
        bus_write(2'd3, 32'h1);
      end
    join
    check("setw1c_irq", {31'b0, irq}, 32'h1);
    bus_read(2'd3, d); check("setw1c_done", d, 32'h1);

    // Reset mid-frame with capture and mask set
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'h1);
    repeat (40) @(negedge clk);
    address = 2'd0;
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_out", {31'b0, out_port}, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    bus_read(2'd0, d); check("midrst_data", d, 32'h0);
    bus_read(2'd2, d); check("midrst_mask", d, 32'h0);
    bus_read(2'd3, d); check("midrst_done", d, 32'h0);
    bus_read(2'd1, d); check("midrst_busy", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
